// File: rtl/friscv_div_ctrl.sv
// friscv_div_ctrl
//   Shares one iterative integer divider between two requesters. Each request
//   carries a RISC-V funct3 (DIV/DIVU/REM/REMU) and two operands. Requests are
//   granted round-robin, run through the divider's valid/ready handshakes, and
//   answered with either the quotient or the remainder.
//
//   Optional feature macro: FRISCV_DIV_CACHE_EN
//     When defined, the operands and results of the last divider completion are
//     kept. A new grant with the same rs1, rs2 and signedness is answered from
//     that copy without running the divider.
//
// Ports
//   aclk, aresetn, srst   clock, async active-low reset, sync active-high reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot)
//   req_funct3            {req1,req0} funct3
//   req_rs1/req_rs2       {req1,req0} dividend / divisor
//   rsp_valid/rsp_ready   per-requester response handshake (valid is one-hot)
//   rsp_data, rsp_zdiv    quotient or remainder, divisor-was-zero flag
//   div_valid/div_ready, div_signed, div_divd, div_divs    divider input side
//   div_o_valid/div_o_ready, div_zero, div_quot, div_rem   divider output side
module friscv_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               srst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [5:0]         req_funct3,
  input  logic [2*WIDTH-1:0] req_rs1,
  input  logic [2*WIDTH-1:0] req_rs2,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_zdiv,
  output logic               div_valid,
  input  logic               div_ready,
  output logic               div_signed,
  output logic [WIDTH-1:0]   div_divd,
  output logic [WIDTH-1:0]   div_divs,
  input  logic               div_o_valid,
  output logic               div_o_ready,
  input  logic               div_zero,
  input  logic [WIDTH-1:0]   div_quot,
  input  logic [WIDTH-1:0]   div_rem
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic               last_gnt;
  logic               gid;
  logic [WIDTH-1:0]   rs1_q, rs2_q, quot_q, rem_q;
  logic               sgn_q, rem_sel_q, zdiv_q;

  logic               take, grant_id, hit;
  logic [WIDTH-1:0]   sel_rs1, sel_rs2;
  logic [2:0]         sel_f3;
  logic [WIDTH-1:0]   hit_quot, hit_rem;
  logic               hit_zdiv;
  logic               unused_f3_msb;

  // Round-robin: with both requesting, the one not granted last wins.
  assign grant_id = (&req_valid) ? ~last_gnt : req_valid[1];
  assign take     = (state == IDLE) && (|req_valid);
  assign sel_rs1  = grant_id ? req_rs1[2*WIDTH-1:WIDTH] : req_rs1[WIDTH-1:0];
  assign sel_rs2  = grant_id ? req_rs2[2*WIDTH-1:WIDTH] : req_rs2[WIDTH-1:0];
  assign sel_f3   = grant_id ? req_funct3[5:3] : req_funct3[2:0];
  // Only M-extension divide opcodes reach this block; bit 2 is always set.
  assign unused_f3_msb = sel_f3[2];

  // Ready is masked while any reset is active so no grant is seen during reset.
  assign req_ready = (take && aresetn && !srst) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

  assign div_divd   = rs1_q;
  assign div_divs   = rs2_q;
  assign div_signed = sgn_q;
  assign rsp_data   = rem_sel_q ? rem_q : quot_q;
  assign rsp_zdiv   = zdiv_q;

`ifdef FRISCV_DIV_CACHE_EN
  logic               c_vld, c_sgn, c_zdiv;
  logic [WIDTH-1:0]   c_rs1, c_rs2, c_quot, c_rem;

  assign hit      = c_vld && (c_rs1 == sel_rs1) && (c_rs2 == sel_rs2) && (c_sgn == ~sel_f3[0]);
  assign hit_quot = c_quot;
  assign hit_rem  = c_rem;
  assign hit_zdiv = c_zdiv;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      c_vld <= 1'b0; c_sgn <= 1'b0; c_zdiv <= 1'b0;
      c_rs1 <= '0;   c_rs2 <= '0;   c_quot <= '0;  c_rem <= '0;
    end else if (srst) begin
      c_vld <= 1'b0; c_sgn <= 1'b0; c_zdiv <= 1'b0;
      c_rs1 <= '0;   c_rs2 <= '0;   c_quot <= '0;  c_rem <= '0;
    end else if (state == WAIT && div_o_valid) begin
      c_vld  <= 1'b1;
      c_rs1  <= rs1_q;
      c_rs2  <= rs2_q;
      c_sgn  <= sgn_q;
      c_quot <= div_quot;
      c_rem  <= div_rem;
      c_zdiv <= div_zero;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_quot = '0;
  assign hit_rem  = '0;
  assign hit_zdiv = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      last_gnt <= 1'b1;
    end else if (srst) begin
      state <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (take) last_gnt <= grant_id;
    end
  end

  always_comb begin
    state_nxt   = state;
    div_valid   = 1'b0;
    div_o_ready = 1'b0;
    rsp_valid   = 2'b00;
    case (state)
      IDLE:  if (|req_valid) state_nxt = hit ? RESP : ISSUE;
      // A lingering div_o_valid from the previous result blocks the issue.
      ISSUE: if (div_ready && !div_o_valid) begin
               div_valid = 1'b1;
               state_nxt = WAIT;
             end
      WAIT:  begin
               div_o_ready = 1'b1;
               if (div_o_valid) state_nxt = RESP;
             end
      RESP:  begin
               rsp_valid = gid ? 2'b10 : 2'b01;
               if (rsp_ready[gid]) state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gid <= 1'b0; sgn_q <= 1'b0; rem_sel_q <= 1'b0; zdiv_q <= 1'b0;
      rs1_q <= '0; rs2_q <= '0;   quot_q <= '0;      rem_q <= '0;
    end else if (srst) begin
      gid <= 1'b0; sgn_q <= 1'b0; rem_sel_q <= 1'b0; zdiv_q <= 1'b0;
      rs1_q <= '0; rs2_q <= '0;   quot_q <= '0;      rem_q <= '0;
    end else begin
      if (take) begin
        gid       <= grant_id;
        rs1_q     <= sel_rs1;
        rs2_q     <= sel_rs2;
        sgn_q     <= ~sel_f3[0];
        rem_sel_q <= sel_f3[1];
        if (hit) begin
          quot_q <= hit_quot;
          rem_q  <= hit_rem;
          zdiv_q <= hit_zdiv;
        end
      end
      // Divider corner cases (x/0, MIN/-1) already follow RISC-V; take as-is.
      if (state == WAIT && div_o_valid) begin
        quot_q <= div_quot;
        rem_q  <= div_rem;
        zdiv_q <= div_zero;
      end
    end
  end

endmodule

// File: tb/tb_friscv_div_ctrl.sv
// tb_friscv_div_ctrl
//   Bench for friscv_div_ctrl with a behavioral stand-in for the iterative
//   divider (fixed latency, RISC-V corner-case results). Directed vectors in a
//   table plus hand-written sequences for arbitration, back-pressure and reset.
//   Cache checks are compiled in when FRISCV_DIV_CACHE_EN is defined.
module tb_friscv_div_ctrl;
  localparam int W = 32;

  logic           aclk = 1'b0;
  logic           aresetn, srst;
  logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5:0]     req_funct3;
  logic [2*W-1:0] req_rs1, req_rs2;
  logic [W-1:0]   rsp_data;
  logic           rsp_zdiv;
  logic           div_valid, div_ready, div_signed;
  logic [W-1:0]   div_divd, div_divs;
  logic           div_o_valid, div_o_ready, div_zero;
  logic [W-1:0]   div_quot, div_rem;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  friscv_div_ctrl #(.WIDTH(W)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zdiv(rsp_zdiv),
    .div_valid(div_valid), .div_ready(div_ready), .div_signed(div_signed),
    .div_divd(div_divd), .div_divs(div_divs),
    .div_o_valid(div_o_valid), .div_o_ready(div_o_ready), .div_zero(div_zero),
    .div_quot(div_quot), .div_rem(div_rem)
  );

  // Divider stand-in
  logic        busy;
  int          cnt;
  int          dv_count;
  logic [64:0] res;

  function automatic logic [64:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1; r = a;
      return {1'b1, q, r};
    end
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b; r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  assign div_ready = !busy && !div_o_valid;
  assign {div_zero, div_quot, div_rem} = res;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy <= 1'b0; cnt <= 0; div_o_valid <= 1'b0; res <= '0; dv_count <= 0;
    end else if (srst) begin
      busy <= 1'b0; cnt <= 0; div_o_valid <= 1'b0; res <= '0; dv_count <= 0;
    end else begin
      if (div_valid && div_ready) begin
        busy <= 1'b1; cnt <= 3;
        res <= model_div(div_signed, div_divd, div_divs);
        dv_count <= dv_count + 1;
      end else if (busy) begin
        if (cnt == 0) begin busy <= 1'b0; div_o_valid <= 1'b1; end
        else cnt <= cnt - 1;
      end
      if (div_o_valid && div_o_ready) div_o_valid <= 1'b0;
    end
  end

  logic [103:0] outs;
  assign outs = {req_ready, rsp_valid, rsp_data, rsp_zdiv, div_valid, div_o_ready,
                 div_signed, div_divd, div_divs};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int id);
    return (id == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic wait_grant(input int id);
    int n = 0;
    while (req_ready == 2'b00 && n < 50) begin @(negedge aclk); #1; n++; end
    chk("grant", 128'(req_ready), 128'(onehot(id)));
  endtask

  task automatic wait_rsp(input int id, output int lat);
    lat = 1;
    while (rsp_valid == 2'b00 && lat < 200) begin @(negedge aclk); #1; lat++; end
    chk("rsp_valid", 128'(rsp_valid), 128'(onehot(id)));
  endtask

  task automatic set_req(input int id, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    req_valid[id] = 1'b1;
    if (id == 0) begin
      req_funct3[2:0] = f3; req_rs1[31:0] = a; req_rs2[31:0] = b;
    end else begin
      req_funct3[5:3] = f3; req_rs1[63:32] = a; req_rs2[63:32] = b;
    end
  endtask

  // One full transaction; iss is {div_valid, div_signed, div_divd, div_divs} one
  // cycle after the grant, lat counts cycles from grant to rsp_valid.
  task automatic do_op(input int id, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [65:0] iss, output int lat, output logic [31:0] d, output logic z);
    @(negedge aclk);
    set_req(id, f3, a, b);
    #1;
    wait_grant(id);
    @(negedge aclk);
    req_valid[id] = 1'b0;
    #1;
    iss = {div_valid, div_signed, div_divd, div_divs};
    wait_rsp(id, lat);
    d = rsp_data;
    z = rsp_zdiv;
    rsp_ready[id] = 1'b1;
    @(negedge aclk);
    rsp_ready[id] = 1'b0;
  endtask

  typedef struct {
    int          id;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        z;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [65:0] iss;
    int          lat, g, base;
    logic [31:0] d;
    logic        z;

    tbl[0] = '{0, 3'b100, 32'd100,        32'd7,          32'd14,         1'b0};
    tbl[1] = '{1, 3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{0, 3'b101, 32'hFFFF_FFFE,  32'd2,          32'h7FFF_FFFF,  1'b0};
    tbl[3] = '{1, 3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    tbl[4] = '{0, 3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
    tbl[5] = '{1, 3'b110, 32'd5,          32'd0,          32'd5,          1'b1};
    tbl[6] = '{0, 3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
    tbl[7] = '{1, 3'b101, 32'd7,          32'd100,        32'd0,          1'b0};
    tbl[8] = '{0, 3'b100, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          1'b0};

    // Reset with both requesters already asking: nothing may be granted.
    aresetn = 1'b0; srst = 1'b0; rsp_ready = 2'b00;
    req_valid  = 2'b11;
    req_funct3 = {3'b101, 3'b100};
    req_rs1    = {32'hFFFF_FFFE, 32'd100};
    req_rs2    = {32'd2, 32'd7};
    #23;
    chk("reset_outputs", 128'(outs), 128'(0));

    // Round-robin with both held: 0,1,0,1
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      wait_grant(g);
      @(negedge aclk); #1;
      wait_rsp(g, lat);
      chk("rr_data", 128'(rsp_data), 128'((g == 1) ? 32'h7FFF_FFFF : 32'd14));
      rsp_ready = onehot(g);
      @(negedge aclk);
      rsp_ready = 2'b00;
      if (k == 3) req_valid = 2'b00;
      #1;
    end

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].id, tbl[i].f3, tbl[i].a, tbl[i].b, iss, lat, d, z);
      chk($sformatf("tbl%0d_issue", i), 128'(iss), 128'({1'b1, ~tbl[i].f3[0], tbl[i].a, tbl[i].b}));
      chk($sformatf("tbl%0d_data", i), 128'(d), 128'(tbl[i].q));
      chk($sformatf("tbl%0d_zdiv", i), 128'(z), 128'(tbl[i].z));
    end

    // Response back-pressure; req1 asks and drives its own rsp_ready meanwhile.
    @(negedge aclk);
    set_req(0, 3'b100, 32'd100, 32'd7);
    #1;
    wait_grant(0);
    @(negedge aclk);
    req_valid[0] = 1'b0;
    #1;
    wait_rsp(0, lat);
    set_req(1, 3'b100, 32'd9, 32'd3);
    rsp_ready[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk); #1;
      chk("stall_hold", 128'({rsp_valid, rsp_data, rsp_zdiv, req_ready}),
          128'({2'b01, 32'd14, 1'b0, 2'b00}));
    end
    @(negedge aclk);
    rsp_ready = 2'b01;
    req_valid = 2'b00;
    @(negedge aclk);
    rsp_ready = 2'b00;
    #1;
    chk("stall_release", 128'(rsp_valid), 128'(0));

    // Async reset while waiting on the divider
    @(negedge aclk);
    set_req(1, 3'b100, 32'd100, 32'd7);
    #1;
    wait_grant(1);
    @(negedge aclk);
    req_valid = 2'b00;
    #1;
    @(negedge aclk); #1;
    chk("in_wait", 128'(div_o_ready), 128'(1));
    aresetn = 1'b0;
    #1;
    chk("async_reset_outputs", 128'(outs), 128'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    do_op(0, 3'b100, 32'd100, 32'd7, iss, lat, d, z);
    chk("after_areset_issue", 128'(iss[65]), 128'(1));
    chk("after_areset_data", 128'(d), 128'(14));
    chk("after_areset_zdiv", 128'(z), 128'(0));

    // Sync reset while a response is pending
    @(negedge aclk);
    set_req(1, 3'b111, 32'd100, 32'd7);
    #1;
    wait_grant(1);
    @(negedge aclk);
    req_valid = 2'b00;
    #1;
    wait_rsp(1, lat);
    srst = 1'b1;
    @(negedge aclk);
    srst = 1'b0;
    #1;
    chk("sync_reset_outputs", 128'(outs), 128'(0));

`ifdef FRISCV_DIV_CACHE_EN
    do_op(0, 3'b100, 32'd100, 32'd7, iss, lat, d, z);
    chk("cache_fill_issue", 128'(iss[65]), 128'(1));
    chk("cache_fill_data", 128'(d), 128'(14));
    base = dv_count;
    do_op(0, 3'b110, 32'd100, 32'd7, iss, lat, d, z);
    chk("cache_hit_latency", 128'(lat), 128'(1));
    chk("cache_hit_no_issue", 128'(iss[65]), 128'(0));
    chk("cache_hit_data", 128'(d), 128'(2));
    chk("cache_hit_div_count", 128'(dv_count), 128'(base));
    do_op(0, 3'b111, 32'd100, 32'd7, iss, lat, d, z);
    chk("cache_miss_issue", 128'(iss[65]), 128'(1));
    chk("cache_miss_data", 128'(d), 128'(2));
`else
    base = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
